// File: rtl/timer_multi.sv
// Multi-channel prescaled up-counter timer on the select/we/re peripheral bus.
// Each channel overflows into a W1C pending flag that drives a per-channel interrupt vector.
module timer_multi #(
    parameter int N_CH  = 2,
    parameter int WIDTH = 16,
    parameter int PSC_W = 8,
    parameter int AW    = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sel,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_rdy,
    output logic             o_int_req,
    output logic [N_CH-1:0]  o_int_vec
);
    localparam int CH_W = AW - 2;

    // Bus handshake: i_sel is the request and o_rdy its ready; every selected
    // access completes in the same cycle, so o_rdy simply mirrors i_sel.
    logic [CH_W-1:0] ch_idx;
    logic [1:0]      reg_sel;
    logic            ch_ok;

    assign ch_idx  = i_addr[AW-1:2];
    assign reg_sel = i_addr[1:0];
    assign ch_ok   = int'(ch_idx) < N_CH;
    assign o_rdy   = i_sel;

    logic             en_q      [N_CH];
    logic             int_en_q  [N_CH];
    logic             oneshot_q [N_CH];
    logic             pend_q    [N_CH];
    logic [PSC_W-1:0] psc_q     [N_CH];
    logic [PSC_W-1:0] psc_cnt_q [N_CH];
    logic [WIDTH-1:0] reload_q  [N_CH];
    logic [WIDTH-1:0] count_q   [N_CH];

    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] wr_hit;

    always_comb begin
        tick   = '0;
        wr_hit = '0;
        for (int c = 0; c < N_CH; c++) begin
            tick[c]   = en_q[c] && (psc_cnt_q[c] == psc_q[c]);
            wr_hit[c] = i_sel && i_we && ch_ok && (int'(ch_idx) == c);
        end
    end

    // Statement order sets priority: W1C loses to an overflow set, and bus
    // writes to CTRL/RELOAD/COUNT override the counter's own update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                en_q[c]      <= 1'b0;
                int_en_q[c]  <= 1'b0;
                oneshot_q[c] <= 1'b0;
                pend_q[c]    <= 1'b0;
                psc_q[c]     <= '0;
                psc_cnt_q[c] <= '0;
                reload_q[c]  <= '0;
                count_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (en_q[c]) begin
                    psc_cnt_q[c] <= tick[c] ? '0 : psc_cnt_q[c] + PSC_W'(1);
                end
                if (wr_hit[c] && reg_sel == 2'd1 && i_wdata[0]) begin
                    pend_q[c] <= 1'b0;
                end
                if (tick[c]) begin
                    if (count_q[c] == '1) begin
                        count_q[c] <= reload_q[c];
                        pend_q[c]  <= 1'b1;
                        if (oneshot_q[c]) begin
                            en_q[c] <= 1'b0;
                        end
                    end else begin
                        count_q[c] <= count_q[c] + WIDTH'(1);
                    end
                end
                if (wr_hit[c]) begin
                    case (reg_sel)
                        2'd0: begin
                            en_q[c]      <= i_wdata[0];
                            int_en_q[c]  <= i_wdata[1];
                            oneshot_q[c] <= i_wdata[2];
                            psc_q[c]     <= i_wdata[8 +: PSC_W];
                        end
                        2'd2: begin
                            reload_q[c]  <= i_wdata;
                            count_q[c]   <= i_wdata;
                            psc_cnt_q[c] <= '0;
                        end
                        2'd3: begin
                            count_q[c]   <= i_wdata;
                            psc_cnt_q[c] <= '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_sel && i_re && ch_ok) begin
            for (int c = 0; c < N_CH; c++) begin
                if (int'(ch_idx) == c) begin
                    case (reg_sel)
                        2'd0: begin
                            o_rdata[0]          = en_q[c];
                            o_rdata[1]          = int_en_q[c];
                            o_rdata[2]          = oneshot_q[c];
                            o_rdata[8 +: PSC_W] = psc_q[c];
                        end
                        2'd1:    o_rdata[0] = pend_q[c];
                        2'd2:    o_rdata    = reload_q[c];
                        default: o_rdata    = count_q[c];
                    endcase
                end
            end
        end
    end

    always_comb begin
        o_int_vec = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_int_vec[c] = pend_q[c] & int_en_q[c];
        end
        o_int_req = |o_int_vec;
    end

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: bus reads are checked by a negedge monitor
// against an expected-value queue; interrupt lines are checked at fixed points.
module tb_timer_multi;
    localparam int N_CH  = 2;
    localparam int WIDTH = 16;
    localparam int PSC_W = 8;
    localparam int AW    = 3;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_sel = 1'b0;
    logic             i_we = 1'b0;
    logic             i_re = 1'b0;
    logic [AW-1:0]    i_addr = '0;
    logic [WIDTH-1:0] i_wdata = '0;
    logic [WIDTH-1:0] o_rdata;
    logic             o_rdy;
    logic             o_int_req;
    logic [N_CH-1:0]  o_int_vec;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    string            name_q[$];

    timer_multi #(.N_CH(N_CH), .WIDTH(WIDTH), .PSC_W(PSC_W), .AW(AW)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_sel    (i_sel),
        .i_we     (i_we),
        .i_re     (i_re),
        .i_addr   (i_addr),
        .i_wdata  (i_wdata),
        .o_rdata  (o_rdata),
        .o_rdy    (o_rdy),
        .o_int_req(o_int_req),
        .o_int_vec(o_int_vec)
    );

    always #5 i_clk = ~i_clk;

    // Monitor: every selected read cycle pops one expected value.
    always @(negedge i_clk) begin
        if (i_sel && i_re) begin
            logic [WIDTH-1:0] exp_v;
            string            nm;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected addr=%0h got=%h", i_addr, o_rdata);
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (o_rdata !== exp_v || o_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s got=%h rdy=%b exp=%h", nm, o_rdata, o_rdy, exp_v);
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic bus_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
        @(posedge i_clk); #1;
        i_sel = 1'b0; i_we = 1'b0; i_wdata = '0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, input logic [WIDTH-1:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        i_sel = 1'b1; i_re = 1'b1; i_addr = a;
        @(posedge i_clk); #1;
        i_sel = 1'b0; i_re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic check_int(input logic e_req, input logic [N_CH-1:0] e_vec, input string nm);
        checks++;
        if (o_int_req !== e_req || o_int_vec !== e_vec) begin
            errors++;
            $display("FAIL %s got req=%b vec=%b exp req=%b vec=%b", nm, o_int_req, o_int_vec, e_req, e_vec);
        end
    endtask

    task automatic read_all_zero(input string nm);
        for (int a = 0; a < 8; a++) begin
            bus_read(AW'(a), '0, $sformatf("%s_a%0d", nm, a));
        end
        check_int(1'b0, 2'b00, {nm, "_int"});
    endtask

    initial begin
        check_int(1'b0, 2'b00, "int_in_reset");
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        read_all_zero("reset_rd");

        // ch0: periodic, psc=0, reload 0xFFFC -> overflow every 4 ticks
        bus_write(3'd2, 16'hFFFC);
        bus_write(3'd0, 16'h0003);
        idle(4);
        check_int(1'b1, 2'b01, "ch0_first_ovf");
        bus_read(3'd3, 16'hFFFC, "ch0_count_reloaded");
        bus_read(3'd1, 16'h0001, "ch0_pending");
        bus_write(3'd1, 16'h0001);
        check_int(1'b0, 2'b00, "ch0_w1c_clear");
        idle(1);
        check_int(1'b1, 2'b01, "ch0_periodic_repeat");
        idle(3);
        bus_write(3'd1, 16'h0001);
        check_int(1'b1, 2'b01, "ch0_w1c_vs_ovf");
        bus_read(3'd1, 16'h0001, "ch0_pend_after_collide");
        bus_write(3'd1, 16'h0001);
        check_int(1'b0, 2'b00, "ch0_w1c_next");
        bus_write(3'd0, 16'h0000);
        check_int(1'b0, 2'b00, "ch0_disabled");
        bus_read(3'd1, 16'h0000, "ch0_pend_cleared");
        bus_read(3'd3, 16'hFFFF, "ch0_count_hold_a");
        idle(3);
        bus_read(3'd3, 16'hFFFF, "ch0_count_hold_b");
        bus_read(3'd1, 16'h0000, "ch0_no_pend_when_off");

        // ch1: oneshot, psc=3, reload 0xFFFE -> 2 ticks of 4 cycles each
        bus_write(3'd6, 16'hFFFE);
        bus_write(3'd4, 16'h0305);
        idle(7);
        bus_read(3'd5, 16'h0000, "ch1_not_yet");
        bus_read(3'd5, 16'h0001, "ch1_oneshot_pend");
        check_int(1'b0, 2'b00, "ch1_masked_int");
        bus_read(3'd4, 16'h0304, "ch1_en_cleared");
        bus_read(3'd7, 16'hFFFE, "ch1_count_reloaded");
        bus_write(3'd5, 16'h0001);
        idle(20);
        bus_read(3'd5, 16'h0000, "ch1_no_repend");
        bus_read(3'd7, 16'hFFFE, "ch1_count_holds");

        // ch1: masked overflow, then enabling int_en raises the line
        bus_write(3'd4, 16'h0005);
        idle(2);
        check_int(1'b0, 2'b00, "ch1_masked_again");
        bus_read(3'd5, 16'h0001, "ch1_pend_masked");
        bus_write(3'd4, 16'h0002);
        check_int(1'b1, 2'b10, "ch1_int_en_late");

        // ch1: CTRL write of en=1 on the oneshot expiry edge keeps en=1
        bus_write(3'd5, 16'h0001);
        bus_write(3'd4, 16'h0007);
        idle(1);
        bus_write(3'd4, 16'h0007);
        bus_read(3'd4, 16'h0007, "ch1_ctrl_wins_expiry");
        bus_write(3'd4, 16'h0002);
        check_int(1'b1, 2'b10, "ch1_pend_before_reset");

        // asynchronous reset between clock edges
        #2 i_rst_n = 1'b0;
        #1 check_int(1'b0, 2'b00, "async_reset_int");
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        read_all_zero("post_reset_rd");

        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL read_queue_left got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
